display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter CLOCK_SPEED, default 100000000, system clock frequency in Hz.
REQ-002 Parameter DWELL_MS, default 500, minimum time in ms a grant is held while others wait.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-requester request, bit i = requester i wants the display.
REQ-006 value_in  input  64  requester values, bits [16i+15:16i] = requester i.
REQ-007 grant  output  4  one-hot grant, all zero when idle.
REQ-008 value  output  16  value driven to the display module's value input.
REQ-009 active  output  1  high when any requester is granted.

Function
REQ-010 The block SHALL use states IDLE and SHOW, plus GAP when BLANK_GAP_EN is defined.
REQ-011 DWELL_CYCLES SHALL be CLOCK_SPEED/1000*DWELL_MS; the dwell counter width SHALL be $clog2(DWELL_CYCLES+1).
REQ-012 IDLE: grant=0, active=0, value=16'h0000.
REQ-013 IDLE with req!=0: the winner SHALL be chosen round-robin from the pointer, with grant asserted the next cycle and the dwell counter cleared.
REQ-014 SHOW: value SHALL equal value_in of the granted requester, registered, with one-cycle latency; live updates SHALL pass through.
REQ-015 SHOW: the dwell counter SHALL increment each cycle and saturate at DWELL_CYCLES, never wrapping.
REQ-016 SHOW, granted req deasserted: the grant SHALL be released the next cycle regardless of dwell, going to IDLE, or to GAP if the macro is defined.
REQ-017 SHOW, dwell saturated and another req bit set: the grant SHALL move to the next requester round-robin after the current one, with the counter cleared.
REQ-018 SHOW, dwell saturated and no other req: the current grant SHALL be held indefinitely.
REQ-019 The round-robin pointer SHALL update to the new grantee index on every grant change; search order is pointer+1, pointer+2, ... mod 4.
REQ-020 Simultaneous grantee-release and other requests: release takes effect; the next grant follows REQ-013 from the updated pointer.
REQ-021 The grant SHALL never have more than one bit set; a change SHALL never produce an overlap cycle.

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, grant=0, active=0, value=16'h0000, dwell=0, pointer=3 so that requester 0 wins first.
REQ-023 Reset asserted mid-SHOW or mid-GAP SHALL abort immediately; after release, arbitration restarts per REQ-013.

Configuration
REQ-024 Macro DISPLAY_ARBITER_BLANK_GAP_EN defined: every grant change or release SHALL pass through GAP for exactly 16 cycles with grant=0, active=0, value=16'h0000, then go to SHOW or IDLE per current req.
REQ-025 Macro undefined: no GAP state; transitions are direct, and no gap counter logic SHALL be synthesized.

Structure
REQ-026 Package display_pkg SHALL hold the state enum, NUM_REQ=4, VALUE_W=16 and GAP_CYCLES=16.
REQ-027 Sub-module rr_picker SHALL be purely combinational: req[3:0] and pointer[1:0] in, one-hot pick[3:0] and valid out.
REQ-028 Top level instantiates display_arbiter between the counter and display modules, with the arbiter value output feeding display value.

Verification
REQ-029 Bench parameters SHALL be CLOCK_SPEED=1000 and DWELL_MS=4, giving DWELL_CYCLES=4.
REQ-030 Reset, then req=4'b0001 with value_in[15:0]=16'h1234 -> grant=0001 and active=1 after 1 cycle, value=16'h1234 after 2 cycles.
REQ-031 req=4'b0101 held -> grant alternates 0001/0100 every 5 cycles; no cycle with 2 grant bits set.
REQ-032 Grant on 0010, req[1] drops at dwell=1 -> grant=0 next cycle; with req[3] set, grant=1000 the cycle after.
REQ-033 Only req[2] set for 20 cycles, value_in[47:32] incrementing -> grant stays 0100 and value tracks with 1-cycle lag.
REQ-034 rst_n pulsed low mid-SHOW -> grant=0 and value=0 within the same cycle; after release with req=4'b1111, requester 0 is granted first.
REQ-035 With DISPLAY_ARBITER_BLANK_GAP_EN and req=4'b0011 -> exactly 16 zero-grant cycles between each 0001/0010 handover.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display arbiter.
// The GAP state exists only when DISPLAY_ARBITER_BLANK_GAP_EN is defined.
package display_pkg;

    localparam int NUM_REQ    = 4;
    localparam int VALUE_W    = 16;
    localparam int GAP_CYCLES = 16;
    localparam int PTR_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1
`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) onehot_idx = PTR_W'(i);
        end
    endfunction

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin picker: searches pointer+1, pointer+2, ... mod 4
// and returns a one-hot pick plus a valid flag.
module rr_picker
    import display_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    // Walk from lowest to highest priority so the closest candidate wins last.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = pointer + PTR_W'(k);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/display_arbiter.sv
// Display arbiter: round-robin grant of one display among four requesters with a
// minimum dwell time; DISPLAY_ARBITER_BLANK_GAP_EN inserts a blank GAP on handover.
//
// state | meaning
// IDLE  | no grant, output blank, waiting for any request
// SHOW  | one requester granted, its value forwarded with one-cycle lag
// GAP   | blank interval between grants (only with DISPLAY_ARBITER_BLANK_GAP_EN)
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED = 100000000,
    parameter int unsigned DWELL_MS    = 500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*VALUE_W-1:0] value_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [VALUE_W-1:0]         value,
    output logic                       active
);

    localparam int unsigned DWELL_CYCLES = CLOCK_SPEED / 1000 * DWELL_MS;
    localparam int          DWELL_W      = $clog2(DWELL_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [VALUE_W-1:0]   value_q;
    logic                 active_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [PTR_W-1:0]     ptr_q;

`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0]     gap_q;
`endif

    logic [NUM_REQ-1:0]   pick_req;
    logic [NUM_REQ-1:0]   pick;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic                 grantee_req;
    logic [VALUE_W-1:0]   sel_value;

    // Masking the current grantee means a valid pick in SHOW is always someone else.
    assign pick_req    = req & ~grant_q;
    assign pick_idx    = onehot_idx(pick);
    assign grantee_req = |(req & grant_q);
    assign sel_value   = value_in[{ptr_q, 4'b0000} +: VALUE_W];

    rr_picker u_picker (
        .req     (pick_req),
        .pointer (ptr_q),
        .pick    (pick),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            value_q  <= '0;
            active_q <= 1'b0;
            dwell_q  <= '0;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    value_q <= '0;
                    if (pick_valid) begin
                        state_q  <= SHOW;
                        grant_q  <= pick;
                        active_q <= 1'b1;
                        ptr_q    <= pick_idx;
                        dwell_q  <= '0;
                    end
                end
                SHOW: begin
                    if (!grantee_req) begin
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        value_q  <= '0;
                        dwell_q  <= '0;
`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
                        state_q  <= GAP;
                        gap_q    <= '0;
`else
                        state_q  <= IDLE;
`endif
                    end else if (dwell_q == DWELL_MAX && pick_valid) begin
                        dwell_q <= '0;
`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
                        // Pointer stays on the old grantee; the gap exit picks after it.
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        value_q  <= '0;
                        state_q  <= GAP;
                        gap_q    <= '0;
`else
                        grant_q  <= pick;
                        ptr_q    <= pick_idx;
                        value_q  <= sel_value;
`endif
                    end else begin
                        value_q <= sel_value;
                        if (dwell_q != DWELL_MAX) dwell_q <= dwell_q + 1'b1;
                    end
                end
`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
                GAP: begin
                    value_q <= '0;
                    if (gap_q == GAP_LAST) begin
                        gap_q <= '0;
                        if (pick_valid) begin
                            state_q  <= SHOW;
                            grant_q  <= pick;
                            active_q <= 1'b1;
                            ptr_q    <= pick_idx;
                            dwell_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    active_q <= 1'b0;
                    value_q  <= '0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign value  = value_q;
    assign active = active_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed and randomized bench for display_arbiter against an integer-level
// behavioural model of the arbitration rules (owner, hold time, rotation pointer).
module tb_display_arbiter;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] value_in = '0;
    logic [3:0]  grant;
    logic [15:0] value;
    logic        active;

    int total = 0;
    int bad   = 0;

    int          m_owner = -1;
    int          m_held  = 0;
    int          m_ptr   = 3;
    int          m_gap   = 0;
    logic [15:0] m_val   = '0;

    always #5 clk = ~clk;

    display_arbiter #(.CLOCK_SPEED(1000), .DWELL_MS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .value_in (value_in),
        .grant    (grant),
        .value    (value),
        .active   (active)
    );

    function automatic int next_from(input int ptr, input logic [3:0] r, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (ptr + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_ptr = 3; m_gap = 0; m_val = '0;
    endtask

    task automatic model_leave(input int nxt);
`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
        m_owner = -1; m_gap = 16; m_val = '0; m_held = 0;
`else
        if (nxt < 0) begin
            m_owner = -1; m_val = '0;
        end else begin
            m_owner = nxt; m_ptr = nxt;
        end
        m_held = 0;
`endif
    endtask

    task automatic model_edge();
        int c;
        if (m_gap > 0) begin
            m_val = '0;
            m_gap--;
            if (m_gap == 0) begin
                c = next_from(m_ptr, req, -1);
                if (c >= 0) begin m_owner = c; m_ptr = c; m_held = 0; end
            end
        end else if (m_owner < 0) begin
            m_val = '0;
            c = next_from(m_ptr, req, -1);
            if (c >= 0) begin m_owner = c; m_ptr = c; m_held = 0; end
        end else if (!req[m_owner]) begin
            model_leave(-1);
        end else begin
            c = next_from(m_ptr, req, m_owner);
            if (m_held >= DWELL && c >= 0) begin
                m_val = value_in[m_owner*16 +: 16];
                model_leave(c);
            end else begin
                m_val = value_in[m_owner*16 +: 16];
                if (m_held < DWELL) m_held++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("grant",  {12'h0, grant}, {12'h0, eg});
        check("active", {15'h0, active}, {15'h0, (m_owner >= 0)});
        check("value",  value, m_val);
        check("onehot", 16'($countones(grant) <= 1), 16'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        int run;
        logic [3:0] prev_g;

        // reset state
        #12;
        check("rst_grant", {12'h0, grant}, 16'h0);
        check("rst_active", {15'h0, active}, 16'h0);
        check("rst_value", value, 16'h0);
        rst_n = 1'b1;

        // first grant and value latency
        req = 4'b0001;
        value_in[15:0] = 16'h1234;
        tick();
        check("first_grant", {12'h0, grant}, 16'h0001);
        check("first_active", {15'h0, active}, 16'h1);
        tick();
        check("first_value", value, 16'h1234);

        // two requesters alternate every 5 cycles
        req = 4'b0101;
        value_in = 64'h4444_3333_2222_1111;
        run = 0;
        prev_g = grant;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (grant != prev_g) begin
                if (i > 5) check("alt_period", 16'(run), 16'd5);
                run = 1;
                prev_g = grant;
            end else begin
                run++;
            end
        end

        req = 4'b0000;
        tick();
        tick();

        // early release then hand to requester 3
        req = 4'b0010;
        tick();
        check("g1_grant", {12'h0, grant}, 16'h0002);
        tick();
        req = 4'b1000;
        tick();
        check("release_grant", {12'h0, grant}, 16'h0000);
        tick();
        check("r3_grant", {12'h0, grant}, 16'h0008);

        req = 4'b0000;
        tick();
        tick();

        // lone requester holds and value tracks live updates
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            value_in[47:32] = 16'(16'h0100 + i);
            tick();
        end
        check("hold_grant", {12'h0, grant}, 16'h0004);

        // async reset mid-SHOW
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", {12'h0, grant}, 16'h0);
        check("async_value", value, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        check("post_rst_grant", {12'h0, grant}, 16'h0001);

`ifdef DISPLAY_ARBITER_BLANK_GAP_EN
        req = 4'b0011;
        for (int i = 0; i < 80; i++) tick();
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            value_in = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
